// File: rtl/pc_next_unit_pkg.sv
// Shared constants and types for the next-PC unit.
package pc_next_unit_pkg;

  localparam int unsigned XLEN_DEFAULT       = 32;
  localparam int unsigned OFF_W_DEFAULT      = 16;
  localparam int unsigned INC_DEFAULT        = 4;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

  // Source the PC register loads from on the next edge.
  typedef enum logic [1:0] {
    SEL_INC,
    SEL_HOLD,
    SEL_REDIR,
    SEL_PEND
  } next_sel_e;

  // Instruction fetch addresses must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Request/response bundle between hazard unit / EX stage and the next-PC unit.
interface pc_next_unit_if
  import pc_next_unit_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned OFF_W = OFF_W_DEFAULT
);

  logic             stall;
  logic             br_taken;
  logic [XLEN-1:0]  br_base;
  logic [OFF_W-1:0] br_offset;
  logic             jmp_valid;
  logic [XLEN-1:0]  jmp_target;
  logic             exc_valid;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus_inc;
  logic             flush;
  logic             addr_err;
  logic             pend_valid;

  // Requester side: hazard unit and EX stage.
  modport master (
    output stall, br_taken, br_base, br_offset, jmp_valid, jmp_target, exc_valid,
    input  pc, pc_plus_inc, flush, addr_err, pend_valid
  );

  // The next-PC unit itself.
  modport slave (
    input  stall, br_taken, br_base, br_offset, jmp_valid, jmp_target, exc_valid,
    output pc, pc_plus_inc, flush, addr_err, pend_valid
  );

endinterface

// File: rtl/pc_target_calc.sv
// Redirect target computation: branch adder, priority mux and alignment check.
module pc_target_calc
  import pc_next_unit_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEFAULT,
  parameter int unsigned     OFF_W      = OFF_W_DEFAULT,
  parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(EXC_VECTOR_DEFAULT)
) (
  input  logic             exc_valid_i,
  input  logic             br_taken_i,
  input  logic [XLEN-1:0]  br_base_i,
  input  logic [OFF_W-1:0] br_offset_i,
  input  logic             jmp_valid_i,
  input  logic [XLEN-1:0]  jmp_target_i,
  output logic             req_o,
  output logic             req_exc_o,
  output logic [XLEN-1:0]  target_o,
  output logic             misalign_o
);

  logic [XLEN-1:0] off_ext;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] raw_target;

  // Pick the highest-priority request and vector misaligned branch/jump targets.
  always_comb begin
    off_ext    = XLEN'($signed(br_offset_i));
    br_target  = br_base_i + (off_ext << 2);
    req_o      = exc_valid_i | br_taken_i | jmp_valid_i;
    req_exc_o  = exc_valid_i;
    raw_target = '0;
    if (exc_valid_i) begin
      raw_target = EXC_VECTOR;
    end else if (br_taken_i) begin
      raw_target = br_target;
    end else if (jmp_valid_i) begin
      raw_target = jmp_target_i;
    end
    // Exception vector is trusted; only branch/jump targets are checked.
    misalign_o = !exc_valid_i && (br_taken_i || jmp_valid_i) && is_misaligned(raw_target[1:0]);
    target_o   = misalign_o ? EXC_VECTOR : raw_target;
  end

endmodule

// File: rtl/pc_next_unit.sv
// Fetch PC register with next-PC selection and stall-buffered redirects.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEFAULT,
  parameter int unsigned     OFF_W      = OFF_W_DEFAULT,
  parameter int unsigned     INC        = INC_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(EXC_VECTOR_DEFAULT)
) (
  input logic           clk,
  input logic           rst,
  pc_next_unit_if.slave bus
);

  logic            req;
  logic            req_exc;
  logic [XLEN-1:0] req_target;
  logic            req_misalign;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic            pend_err_q, pend_err_d;
  logic            pend_exc_q, pend_exc_d;
  logic            flush_q, flush_d;
  logic            addr_err_q, addr_err_d;
  next_sel_e       sel;

  pc_target_calc #(
    .XLEN       (XLEN),
    .OFF_W      (OFF_W),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_target_calc (
    .exc_valid_i  (bus.exc_valid),
    .br_taken_i   (bus.br_taken),
    .br_base_i    (bus.br_base),
    .br_offset_i  (bus.br_offset),
    .jmp_valid_i  (bus.jmp_valid),
    .jmp_target_i (bus.jmp_target),
    .req_o        (req),
    .req_exc_o    (req_exc),
    .target_o     (req_target),
    .misalign_o   (req_misalign)
  );

  // Choose the next-PC source and update the pending-redirect buffer.
  always_comb begin
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    pend_err_d   = pend_err_q;
    pend_exc_d   = pend_exc_q;
    flush_d      = 1'b0;
    addr_err_d   = 1'b0;

    if (req && !bus.stall) begin
      sel = SEL_REDIR;
    end else if (req || bus.stall) begin
      sel = SEL_HOLD;
    end else if (pend_valid_q) begin
      sel = SEL_PEND;
    end else begin
      sel = SEL_INC;
    end

    unique case (sel)
      SEL_REDIR: begin
        pc_d         = req_target;
        flush_d      = 1'b1;
        addr_err_d   = req_misalign;
        pend_valid_d = 1'b0;
      end
      SEL_PEND: begin
        pc_d         = pend_pc_q;
        flush_d      = 1'b1;
        addr_err_d   = pend_err_q;
        pend_valid_d = 1'b0;
      end
      SEL_HOLD: begin
        // A buffered exception must not be displaced by a later branch/jump.
        if (req && (req_exc || !(pend_valid_q && pend_exc_q))) begin
          pend_pc_d    = req_target;
          pend_valid_d = 1'b1;
          pend_err_d   = req_misalign;
          pend_exc_d   = req_exc;
        end
      end
      SEL_INC: begin
        pc_d = pc_q + XLEN'(INC);
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // State and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_err_q   <= 1'b0;
      pend_exc_q   <= 1'b0;
      flush_q      <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_err_q   <= pend_err_d;
      pend_exc_q   <= pend_exc_d;
      flush_q      <= flush_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus_inc = pc_q + XLEN'(INC);
  assign bus.flush       = flush_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.pend_valid  = pend_valid_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus randomized traffic vs a model.
module tb_pc_next_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_next_unit_if #(.XLEN(32), .OFF_W(16)) bus ();
  pc_next_unit_if #(.XLEN(16), .OFF_W(12)) bus16 ();

  pc_next_unit #(.XLEN(32), .OFF_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pc_next_unit #(.XLEN(16), .OFF_W(12), .RESET_PC(16'h0000), .EXC_VECTOR(16'h0080)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  // Reference model: PC value, pulse flags and at most one buffered redirect.
  typedef struct {
    logic [31:0] tgt;
    bit          err;
    bit          exc;
  } pend_t;

  logic [31:0] m_pc;
  bit          m_flush;
  bit          m_err;
  pend_t       m_pend[$];

  function automatic void model_reset();
    m_pc    = 32'h0;
    m_flush = 0;
    m_err   = 0;
    m_pend.delete();
  endfunction

  function automatic void model_step();
    bit          have = 0;
    bit          is_exc = 0;
    bit          bad = 0;
    logic [31:0] t = 0;
    logic signed [31:0] off32;
    pend_t       e;
    off32 = 32'($signed(bus.br_offset));
    if (bus.exc_valid) begin
      have = 1; is_exc = 1; t = 32'h80;
    end else if (bus.br_taken) begin
      have = 1; t = bus.br_base + off32 * 4;
    end else if (bus.jmp_valid) begin
      have = 1; t = bus.jmp_target;
    end
    if (have && !is_exc && (t % 4 != 0)) begin
      bad = 1; t = 32'h80;
    end
    m_flush = 0;
    m_err   = 0;
    if (have && !bus.stall) begin
      m_pc = t; m_flush = 1; m_err = bad; m_pend.delete();
    end else if (have) begin
      if (m_pend.size() == 0 || !m_pend[0].exc || is_exc) begin
        e.tgt = t; e.err = bad; e.exc = is_exc;
        m_pend.delete();
        m_pend.push_back(e);
      end
    end else if (m_pend.size() > 0 && !bus.stall) begin
      m_pc = m_pend[0].tgt; m_flush = 1; m_err = m_pend[0].err; m_pend.delete();
    end else if (!bus.stall) begin
      m_pc = m_pc + 4;
    end
  endfunction

  task automatic clear_inputs();
    bus.stall = 0; bus.br_taken = 0; bus.br_base = 0; bus.br_offset = 0;
    bus.jmp_valid = 0; bus.jmp_target = 0; bus.exc_valid = 0;
  endtask

  // Advance one clock with the model in lockstep; outputs settle 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.pc !== 32'h0 || bus.flush !== 1'b0 || bus.addr_err !== 1'b0 || bus.pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pc=%h flush=%b err=%b pend=%b exp pc=0 all flags 0",
               bus.pc, bus.flush, bus.addr_err, bus.pend_valid);
    end
    rst = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'(i * 4);
      checks++;
      if (bus.pc !== exp_pc || bus.flush !== 1'b0 || bus.pc_plus_inc !== exp_pc + 32'd4) begin
        errors++;
        $display("FAIL free_run[%0d] pc=%h inc=%h flush=%b exp pc=%h inc=%h flush=0",
                 i, bus.pc, bus.pc_plus_inc, bus.flush, exp_pc, exp_pc + 32'd4);
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_branch();
    bus.jmp_valid = 1; bus.jmp_target = 32'h100;
    tick();
    clear_inputs();
    checks++;
    if (bus.pc !== 32'h100) begin
      errors++; $display("FAIL br_setup pc=%h exp=00000100", bus.pc);
    end
    bus.br_taken = 1; bus.br_base = 32'h104; bus.br_offset = 16'hFFFE;
    tick();
    clear_inputs();
    checks++;
    if (bus.pc !== 32'h0FC || bus.flush !== 1'b1) begin
      errors++; $display("FAIL br_neg pc=%h flush=%b exp pc=000000fc flush=1", bus.pc, bus.flush);
    end
    tick();
    checks++;
    if (bus.pc !== 32'h100 || bus.flush !== 1'b0) begin
      errors++; $display("FAIL br_after pc=%h flush=%b exp pc=00000100 flush=0", bus.pc, bus.flush);
    end
  endtask

  task automatic test_stall_jump();
    logic [31:0] held;
    held = m_pc;
    bus.stall = 1; bus.jmp_valid = 1; bus.jmp_target = 32'h400;
    tick();
    bus.jmp_valid = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.pc !== held || bus.pend_valid !== 1'b1 || bus.flush !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] pc=%h pend=%b flush=%b exp pc=%h pend=1 flush=0",
                 i, bus.pc, bus.pend_valid, bus.flush, held);
      end
      if (i == 0) tick();
    end
    bus.stall = 0;
    tick();
    checks++;
    if (bus.pc !== 32'h400 || bus.flush !== 1'b1 || bus.pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release pc=%h flush=%b pend=%b exp pc=00000400 flush=1 pend=0",
               bus.pc, bus.flush, bus.pend_valid);
    end
  endtask

  task automatic test_priority();
    bus.exc_valid = 1; bus.br_taken = 1; bus.br_base = 32'h200; bus.br_offset = 16'h10;
    bus.jmp_valid = 1; bus.jmp_target = 32'h800;
    tick();
    clear_inputs();
    checks++;
    if (bus.pc !== 32'h80 || bus.flush !== 1'b1) begin
      errors++; $display("FAIL prio_same pc=%h flush=%b exp pc=00000080 flush=1", bus.pc, bus.flush);
    end
    tick();
    bus.stall = 1; bus.exc_valid = 1;
    tick();
    bus.exc_valid = 0; bus.br_taken = 1; bus.br_base = 32'h200; bus.br_offset = 16'h4;
    tick();
    bus.br_taken = 0;
    checks++;
    if (bus.pend_valid !== 1'b1) begin
      errors++; $display("FAIL prio_pend pend=%b exp=1", bus.pend_valid);
    end
    bus.stall = 0;
    tick();
    checks++;
    if (bus.pc !== 32'h80 || bus.flush !== 1'b1) begin
      errors++; $display("FAIL prio_exc_kept pc=%h flush=%b exp pc=00000080 flush=1", bus.pc, bus.flush);
    end
  endtask

  task automatic test_misalign();
    bus.jmp_valid = 1; bus.jmp_target = 32'h402;
    tick();
    clear_inputs();
    checks++;
    if (bus.pc !== 32'h80 || bus.addr_err !== 1'b1 || bus.flush !== 1'b1) begin
      errors++;
      $display("FAIL mis_direct pc=%h err=%b flush=%b exp pc=00000080 err=1 flush=1",
               bus.pc, bus.addr_err, bus.flush);
    end
    tick();
    checks++;
    if (bus.addr_err !== 1'b0) begin
      errors++; $display("FAIL mis_pulse err=%b exp=0", bus.addr_err);
    end
    bus.stall = 1; bus.jmp_valid = 1; bus.jmp_target = 32'h402;
    tick();
    clear_inputs();
    checks++;
    if (bus.addr_err !== 1'b0 || bus.pend_valid !== 1'b1) begin
      errors++; $display("FAIL mis_capture err=%b pend=%b exp err=0 pend=1", bus.addr_err, bus.pend_valid);
    end
    tick();
    checks++;
    if (bus.pc !== 32'h80 || bus.addr_err !== 1'b1 || bus.flush !== 1'b1) begin
      errors++;
      $display("FAIL mis_apply pc=%h err=%b flush=%b exp pc=00000080 err=1 flush=1",
               bus.pc, bus.addr_err, bus.flush);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      bus.stall      = ($urandom_range(0, 99) < 30);
      bus.exc_valid  = ($urandom_range(0, 99) < 5);
      bus.br_taken   = ($urandom_range(0, 99) < 15);
      bus.jmp_valid  = ($urandom_range(0, 99) < 12);
      bus.br_base    = $urandom();
      if ($urandom_range(0, 3) != 0) bus.br_base[1:0] = 2'b00;
      bus.br_offset  = 16'($urandom());
      bus.jmp_target = $urandom();
      if ($urandom_range(0, 3) != 0) bus.jmp_target[1:0] = 2'b00;
      tick();
      checks++;
      if (bus.pc !== m_pc || bus.flush !== m_flush || bus.addr_err !== m_err ||
          bus.pend_valid !== (m_pend.size() != 0) || bus.pc_plus_inc !== m_pc + 32'd4) begin
        errors++;
        $display("FAIL random[%0d] pc=%h inc=%h flush=%b err=%b pend=%b exp pc=%h inc=%h flush=%b err=%b pend=%b",
                 i, bus.pc, bus.pc_plus_inc, bus.flush, bus.addr_err, bus.pend_valid,
                 m_pc, m_pc + 32'd4, m_flush, m_err, (m_pend.size() != 0));
      end
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    bus.stall = 1; bus.jmp_valid = 1; bus.jmp_target = 32'h300;
    tick();
    bus.jmp_valid = 0;
    checks++;
    if (bus.pend_valid !== 1'b1) begin
      errors++; $display("FAIL arst_setup pend=%b exp=1", bus.pend_valid);
    end
    #3;
    rst = 1;
    #1;
    checks++;
    if (bus.pc !== 32'h0 || bus.pend_valid !== 1'b0 || bus.flush !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate pc=%h pend=%b flush=%b exp pc=0 pend=0 flush=0",
               bus.pc, bus.pend_valid, bus.flush);
    end
    @(posedge clk);
    #1;
    rst = 0;
    bus.stall = 0;
    model_reset();
    tick();
    checks++;
    if (bus.pc !== 32'h4 || bus.flush !== 1'b0) begin
      errors++; $display("FAIL arst_discard pc=%h flush=%b exp pc=00000004 flush=0", bus.pc, bus.flush);
    end
  endtask

  task automatic test_xlen16();
    bus16.jmp_valid = 1; bus16.jmp_target = 16'hFFFC;
    tick();
    bus16.jmp_valid = 0;
    checks++;
    if (bus16.pc !== 16'hFFFC || bus16.pc_plus_inc !== 16'h0000) begin
      errors++; $display("FAIL x16_top pc=%h inc=%h exp pc=fffc inc=0000", bus16.pc, bus16.pc_plus_inc);
    end
    tick();
    checks++;
    if (bus16.pc !== 16'h0000) begin
      errors++; $display("FAIL x16_wrap pc=%h exp=0000", bus16.pc);
    end
  endtask

  initial begin
    clear_inputs();
    bus16.stall = 0; bus16.br_taken = 0; bus16.br_base = 0; bus16.br_offset = 0;
    bus16.jmp_valid = 0; bus16.jmp_target = 0; bus16.exc_valid = 0;
    model_reset();
    test_reset();
    test_branch();
    test_stall_jump();
    test_priority();
    test_misalign();
    test_random();
    test_async_reset();
    test_xlen16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
